// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants and FSM state type for the data cache controller
package dcache_pkg;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int OFFSET_W = 5;
  localparam int WORDS_PER_LINE = 8;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT} state_t;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU load/store port and memory block port of the data cache
interface dcache_if;
  import dcache_pkg::*;
  logic cpu_req_valid;
  logic cpu_req_ready;
  logic cpu_req_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic cpu_resp_valid;
  logic [WORD_W-1:0] cpu_rdata;
  logic mem_write_en_block;
  logic [ADDR_W-1:0] mem_block_addr_wr;
  logic [LINE_W-1:0] mem_write_block;
  logic mem_read_block_en;
  logic [ADDR_W-1:0] mem_block_addr_rd;
  logic [LINE_W-1:0] mem_read_block;
  modport master (
    output cpu_req_valid, cpu_req_we, cpu_addr, cpu_wdata, mem_read_block,
    input cpu_req_ready, cpu_resp_valid, cpu_rdata, mem_write_en_block, mem_block_addr_wr,
    mem_write_block, mem_read_block_en, mem_block_addr_rd
  );
  modport slave (
    input cpu_req_valid, cpu_req_we, cpu_addr, cpu_wdata, mem_read_block,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata, mem_write_en_block, mem_block_addr_wr,
    mem_write_block, mem_read_block_en, mem_block_addr_rd
  );
endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: per-line data, tag, valid and dirty storage with one combinational read port
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  logic              full,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [2:0]        word_sel,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              dirty_set,
  output logic [LINE_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty
);
  logic [LINE_W-1:0] data [NUM_LINES];
  logic [TAG_W-1:0] tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid, dirty;
  assign rd_data = data[idx];
  assign rd_tag = tags[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  // line data and tag writes; contents of invalid lines are never observed so no reset
  always_ff @(posedge clk) begin
    if (we) begin
      if (full) begin
        data[idx] <= wr_line;
        tags[idx] <= wr_tag;
      end else data[idx][{word_sel, 5'b0} +: WORD_W] <= wr_word;
    end
  end
  // valid/dirty state; a fill installs a clean line, a word write may mark it dirty
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[idx] <= valid[idx] | full;
      dirty[idx] <= full ? dirty_set : dirty[idx] | dirty_set;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate cache controller; DCACHE_STATS_EN adds event counters
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input logic clk,
  input logic reset,
  dcache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;
  state_t state, nxt;
  logic req_we;
  logic [ADDR_W-1:2] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag, l_tag;
  logic [2:0] word;
  logic [LINE_W-1:0] l_data;
  logic l_valid, l_dirty, hit, accept, unused_lsb;
  assign idx = req_addr[OFFSET_W +: IDX_W];
  assign tag = req_addr[ADDR_W-1 -: TAG_W];
  assign word = req_addr[4:2];
  assign accept = bus.cpu_req_valid & bus.cpu_req_ready;
  assign hit = state == LOOKUP && l_valid && l_tag == tag;
  assign unused_lsb = ^bus.cpu_addr[1:0];
  dcache_line_store #(.NUM_LINES(NUM_LINES)) u_store (
    .clk(clk),
    .reset(reset),
    .idx(idx),
    .we((hit & req_we) | (state == FILL_WAIT)),
    .full(state == FILL_WAIT),
    .wr_tag(tag),
    .wr_line(bus.mem_read_block),
    .word_sel(word),
    .wr_word(req_wdata),
    .dirty_set(state != FILL_WAIT),
    .rd_data(l_data),
    .rd_tag(l_tag),
    .rd_valid(l_valid),
    .rd_dirty(l_dirty)
  );
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  // next state and memory-side strobes; addresses and victim data are zero unless strobing
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = accept ? LOOKUP : IDLE;
      LOOKUP:    nxt = hit ? IDLE : (l_valid && l_dirty) ? WRITEBACK : FILL_REQ;
      WRITEBACK: nxt = FILL_REQ;
      FILL_REQ:  nxt = FILL_WAIT;
      FILL_WAIT: nxt = LOOKUP;
      default:   nxt = IDLE;
    endcase
    bus.cpu_req_ready = state == IDLE;
    bus.mem_write_en_block = state == WRITEBACK;
    bus.mem_block_addr_wr = state == WRITEBACK ? {l_tag, idx, {OFFSET_W{1'b0}}} : '0;
    bus.mem_write_block = state == WRITEBACK ? l_data : '0;
    bus.mem_read_block_en = state == FILL_REQ;
    bus.mem_block_addr_rd = state == FILL_REQ ? {tag, idx, {OFFSET_W{1'b0}}} : '0;
  end
  // request latch, held for the whole miss sequence so the replay sees the same request
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we <= bus.cpu_req_we;
      req_addr <= bus.cpu_addr[ADDR_W-1:2];
      req_wdata <= bus.cpu_wdata;
    end
  end
  // response pulse and load data; only a hit in LOOKUP completes a request
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      bus.cpu_resp_valid <= hit;
      if (hit && !req_we) bus.cpu_rdata <= l_data[{word, 5'b0} +: WORD_W];
    end
  end
`ifdef DCACHE_STATS_EN
  logic replay;
  // saturating event counters; replay marks the post-fill LOOKUP so it is not counted again
  always_ff @(posedge clk) begin
    if (reset) begin
      replay <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
      wb_count <= '0;
    end else begin
      if (accept) replay <= 1'b0;
      else if (state == LOOKUP && !hit) replay <= 1'b1;
      if (hit && !replay && hit_count != '1) hit_count <= hit_count + 1;
      if (state == LOOKUP && !hit && !replay && miss_count != '1) miss_count <= miss_count + 1;
      if (state == WRITEBACK && wb_count != '1) wb_count <= wb_count + 1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and randomized checks of dcache_ctrl against a flat-memory reference model
module tb_dcache_ctrl;
  import dcache_pkg::*;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  dcache_if bus ();
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif
  dcache_ctrl #(.NUM_LINES(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );
  int vectors = 0;
  int errors = 0;
  // backing memory: fixed initial image plus blocks written back by the cache
  logic [LINE_W-1:0] wmem [2048];
  bit wv [2048];
  logic [LINE_W-1:0] rd_q = '0;
  int n_rd = 0, n_wr = 0, n_both = 0;
  logic [15:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [LINE_W-1:0] last_wr_blk = '0;
  function automatic logic [LINE_W-1:0] init_blk(int b);
    logic [LINE_W-1:0] r = '0;
    for (int w = 0; w < 8; w++) begin
      if (b == 0) r[32*w +: 32] = 32'h1000_0000 + w;
      else if (b == 1024) r[32*w +: 32] = 32'h2000_0000 + w;
    end
    return r;
  endfunction
  function automatic logic [LINE_W-1:0] backing(int b);
    return wv[b] ? wmem[b] : init_blk(b);
  endfunction
  always @(posedge clk) begin
    if (bus.mem_read_block_en) begin
      rd_q <= backing(int'(bus.mem_block_addr_rd[15:5]));
      n_rd <= n_rd + 1;
      last_rd_addr <= bus.mem_block_addr_rd;
    end
    if (bus.mem_write_en_block) begin
      wmem[int'(bus.mem_block_addr_wr[15:5])] <= bus.mem_write_block;
      wv[int'(bus.mem_block_addr_wr[15:5])] <= 1'b1;
      n_wr <= n_wr + 1;
      last_wr_addr <= bus.mem_block_addr_wr;
      last_wr_blk <= bus.mem_write_block;
    end
    if (bus.mem_read_block_en && bus.mem_write_en_block) n_both <= n_both + 1;
  end
  assign bus.mem_read_block = rd_q;
  // reference: CPU-visible words stored since reset over the backing memory, plus a tag directory for timing
  logic [31:0] refm [int];
  bit mv [16];
  bit md [16];
  int mt [16];
  logic [31:0] m_rdata = '0;
  function automatic logic [31:0] ref_rd(logic [15:0] a);
    logic [LINE_W-1:0] blk;
    if (refm.exists(int'(a[15:2]))) return refm[int'(a[15:2])];
    blk = backing(int'(a[15:5]));
    return blk[{a[4:2], 5'b0} +: 32];
  endfunction
  task automatic model_reset();
    refm.delete();
    for (int i = 0; i < 16; i++) mv[i] = 0;
    m_rdata = '0;
  endtask
  task automatic model(input logic we, input logic [15:0] a, input logic [31:0] d, output int lat,
                       output logic [31:0] rd, output bit miss, output bit wb,
                       output logic [15:0] wba, output logic [LINE_W-1:0] wbb);
    int idx = int'(a[8:5]);
    int tag = int'(a[15:9]);
    miss = !(mv[idx] && mt[idx] == tag);
    wb = miss && mv[idx] && md[idx];
    wba = '0;
    wbb = '0;
    lat = !miss ? 2 : wb ? 6 : 5;
    if (wb) begin
      wba = 16'((mt[idx] * 16 + idx) * 32);
      for (int w = 0; w < 8; w++) wbb[32*w +: 32] = ref_rd(wba + 16'(4 * w));
    end
    if (miss) begin
      mv[idx] = 1;
      mt[idx] = tag;
      md[idx] = 0;
    end
    if (we) begin
      refm[int'(a[15:2])] = d;
      md[idx] = 1;
    end else m_rdata = ref_rd(a);
    rd = m_rdata;
  endtask
  // issues one request at a negedge in IDLE and measures it; optionally drives junk requests while busy
  task automatic xfer(input logic we, input logic [15:0] a, input logic [31:0] d, input bit junk,
                      output int lat, output logic [31:0] rd, output int drd, output int dwr, output int db);
    int r0 = n_rd, w0 = n_wr, b0 = n_both;
    bit got = 0;
    bus.cpu_req_valid = 1;
    bus.cpu_req_we = we;
    bus.cpu_addr = a;
    bus.cpu_wdata = d;
    @(posedge clk);
    #1 bus.cpu_req_valid = 0;
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_resp_valid) got = 1;
      else if (junk) begin
        bus.cpu_req_valid = !bus.cpu_req_ready;
        bus.cpu_req_we = 1'($urandom);
        bus.cpu_addr = 16'($urandom);
        bus.cpu_wdata = $urandom;
      end
    end
    bus.cpu_req_valid = 0;
    rd = bus.cpu_rdata;
    drd = n_rd - r0;
    dwr = n_wr - w0;
    db = n_both - b0;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", bus.cpu_req_ready);
    end
    vectors++;
    if ({bus.cpu_resp_valid, bus.cpu_rdata, bus.mem_write_en_block, bus.mem_block_addr_wr, bus.mem_write_block,
         bus.mem_read_block_en, bus.mem_block_addr_rd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: resp=%b rdata=%h wen=%b wa=%h ren=%b ra=%h expected all zero",
               bus.cpu_resp_valid, bus.cpu_rdata, bus.mem_write_en_block, bus.mem_block_addr_wr,
               bus.mem_read_block_en, bus.mem_block_addr_rd);
    end
`ifdef DCACHE_STATS_EN
    vectors++;
    if ({hit_count, miss_count, wb_count} !== '0) begin
      errors++;
      $display("FAIL reset_stats: hit=%0d miss=%0d wb=%0d expected 0 0 0", hit_count, miss_count, wb_count);
    end
`endif
    reset = 0;
    model_reset();
  endtask
  task automatic test_cold_miss();
    int lat, drd, dwr, db, el;
    logic [31:0] rd, er;
    bit em, ew;
    logic [15:0] ea;
    logic [LINE_W-1:0] eb;
    model(0, 16'h0008, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h0008, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 5 || rd !== 32'h1000_0002 || drd !== 1 || dwr !== 0 || last_rd_addr !== 16'h0000) begin
      errors++;
      $display("FAIL cold_load: lat=%0d rd=%h nrd=%0d nwr=%0d ra=%h expected lat=5 rd=10000002 nrd=1 nwr=0 ra=0000",
               lat, rd, drd, dwr, last_rd_addr);
    end
    model(0, 16'h000C, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h000C, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 2 || rd !== 32'h1000_0003 || drd !== 0 || dwr !== 0) begin
      errors++;
      $display("FAIL hit_load: lat=%0d rd=%h nrd=%0d nwr=%0d expected lat=2 rd=10000003 nrd=0 nwr=0",
               lat, rd, drd, dwr);
    end
  endtask
  task automatic test_store_hit();
    int lat, drd, dwr, db, el;
    logic [31:0] rd, er;
    bit em, ew;
    logic [15:0] ea;
    logic [LINE_W-1:0] eb;
    model(1, 16'h0004, 32'hDEAD_BEEF, el, er, em, ew, ea, eb);
    xfer(1, 16'h0004, 32'hDEAD_BEEF, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 2 || rd !== 32'h1000_0003 || drd !== 0 || dwr !== 0) begin
      errors++;
      $display("FAIL store_hit: lat=%0d rd=%h nrd=%0d nwr=%0d expected lat=2 rd=10000003 nrd=0 nwr=0",
               lat, rd, drd, dwr);
    end
    model(0, 16'h0004, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h0004, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_readback: lat=%0d rd=%h expected lat=2 rd=deadbeef", lat, rd);
    end
  endtask
  task automatic test_dirty_evict();
    int lat, drd, dwr, db, el;
    logic [31:0] rd, er;
    bit em, ew;
    logic [15:0] ea;
    logic [LINE_W-1:0] eb, exp_blk;
    exp_blk = init_blk(0);
    exp_blk[63:32] = 32'hDEAD_BEEF;
    model(0, 16'h8000, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h8000, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 6 || rd !== 32'h2000_0000 || dwr !== 1 || drd !== 1 || db !== 0 || last_rd_addr !== 16'h8000) begin
      errors++;
      $display("FAIL dirty_miss: lat=%0d rd=%h nwr=%0d nrd=%0d both=%0d ra=%h expected lat=6 rd=20000000 nwr=1 nrd=1 both=0 ra=8000",
               lat, rd, dwr, drd, db, last_rd_addr);
    end
    vectors++;
    if (last_wr_addr !== 16'h0000 || last_wr_blk !== exp_blk) begin
      errors++;
      $display("FAIL victim: wa=%h w1=%h w0=%h expected wa=0000 w1=deadbeef w0=10000000",
               last_wr_addr, last_wr_blk[63:32], last_wr_blk[31:0]);
    end
  endtask
`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    vectors++;
    if (hit_count !== 3 || miss_count !== 2 || wb_count !== 1) begin
      errors++;
      $display("FAIL stats: hit=%0d miss=%0d wb=%0d expected 3 2 1", hit_count, miss_count, wb_count);
    end
  endtask
`endif
  task automatic test_store_miss();
    int lat, drd, dwr, db, el;
    logic [31:0] rd, er;
    bit em, ew;
    logic [15:0] ea;
    logic [LINE_W-1:0] eb;
    model(1, 16'h0104, 32'h1234_5678, el, er, em, ew, ea, eb);
    xfer(1, 16'h0104, 32'h1234_5678, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 5 || drd !== 1 || dwr !== 0 || last_rd_addr !== 16'h0100 || rd !== 32'h2000_0000) begin
      errors++;
      $display("FAIL store_miss: lat=%0d nrd=%0d nwr=%0d ra=%h rd=%h expected lat=5 nrd=1 nwr=0 ra=0100 rd=20000000",
               lat, drd, dwr, last_rd_addr, rd);
    end
    model(0, 16'h0104, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h0104, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 2 || rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alloc_read: lat=%0d rd=%h expected lat=2 rd=12345678", lat, rd);
    end
    model(0, 16'h0100, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h0100, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 2 || rd !== 32'h0) begin
      errors++;
      $display("FAIL alloc_neighbor: lat=%0d rd=%h expected lat=2 rd=00000000", lat, rd);
    end
  endtask
  task automatic test_reset_midfill();
    int lat, drd, dwr, db, el;
    logic [31:0] rd, er;
    bit em, ew;
    logic [15:0] ea;
    logic [LINE_W-1:0] eb;
    model(0, 16'h8004, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h8004, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 2 || rd !== 32'h2000_0001) begin
      errors++;
      $display("FAIL pre_reset_load: lat=%0d rd=%h expected lat=2 rd=20000001", lat, rd);
    end
    bus.cpu_req_valid = 1;
    bus.cpu_req_we = 0;
    bus.cpu_addr = 16'h0040;
    @(posedge clk);
    #1 bus.cpu_req_valid = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.mem_read_block_en !== 1'b1 || bus.mem_block_addr_rd !== 16'h0040) begin
      errors++;
      $display("FAIL fill_req: ren=%b ra=%h expected ren=1 ra=0040", bus.mem_read_block_en, bus.mem_block_addr_rd);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    vectors++;
    if (bus.cpu_resp_valid !== 1'b0 || bus.cpu_req_ready !== 1'b1 || bus.cpu_rdata !== '0 ||
        bus.mem_read_block_en !== 1'b0 || bus.mem_write_en_block !== 1'b0 ||
        bus.mem_block_addr_rd !== '0 || bus.mem_block_addr_wr !== '0) begin
      errors++;
      $display("FAIL midfill_reset: resp=%b ready=%b rdata=%h ren=%b wen=%b expected resp=0 ready=1 rdata=0 ren=0 wen=0",
               bus.cpu_resp_valid, bus.cpu_req_ready, bus.cpu_rdata, bus.mem_read_block_en, bus.mem_write_en_block);
    end
    reset = 0;
    model_reset();
    model(0, 16'h8000, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h8000, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 5 || rd !== 32'h2000_0000 || drd !== 1 || dwr !== 0) begin
      errors++;
      $display("FAIL post_reset_miss: lat=%0d rd=%h nrd=%0d nwr=%0d expected lat=5 rd=20000000 nrd=1 nwr=0",
               lat, rd, drd, dwr);
    end
    model(0, 16'h0104, 0, el, er, em, ew, ea, eb);
    xfer(0, 16'h0104, 0, 0, lat, rd, drd, dwr, db);
    vectors++;
    if (lat !== 5 || rd !== 32'h0 || dwr !== 0) begin
      errors++;
      $display("FAIL dirty_discarded: lat=%0d rd=%h nwr=%0d expected lat=5 rd=00000000 nwr=0", lat, rd, dwr);
    end
  endtask
  task automatic test_random();
    int lat, drd, dwr, db, el;
    logic [31:0] rd, er, d;
    bit em, ew, we;
    logic [15:0] ea, a;
    logic [LINE_W-1:0] eb;
    logic [6:0] t;
    logic [3:0] ix;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: t = 7'd0;
        1: t = 7'd1;
        2: t = 7'd2;
        default: t = 7'd64;
      endcase
      ix = $urandom_range(0, 3) == 0 ? 4'd15 : 4'($urandom_range(0, 15));
      a = {t, ix, 5'($urandom)};
      we = 1'($urandom);
      d = $urandom;
      model(we, a, d, el, er, em, ew, ea, eb);
      xfer(we, a, d, 1, lat, rd, drd, dwr, db);
      vectors++;
      if (lat !== el || rd !== er || drd !== int'(em) || dwr !== int'(ew) || db !== 0 ||
          (em && last_rd_addr !== {a[15:5], 5'b0}) || (ew && (last_wr_addr !== ea || last_wr_blk !== eb))) begin
        errors++;
        $display("FAIL rand[%0d] we=%b a=%h: lat=%0d rd=%h nrd=%0d nwr=%0d both=%0d ra=%h wa=%h expected lat=%0d rd=%h nrd=%0d nwr=%0d both=0 ra=%h wa=%h",
                 n, we, a, lat, rd, drd, dwr, db, last_rd_addr, last_wr_addr, el, er, em, ew, {a[15:5], 5'b0}, ea);
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.cpu_req_valid = 0;
    bus.cpu_req_we = 0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    test_reset();
    test_cold_miss();
    test_store_hit();
    test_dirty_evict();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    test_store_miss();
    test_reset_midfill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
